param_uart: RTL

Parametrised full-duplex UART and successor to the fixed 8N1 high-speed UART.
- Configurable at elaboration time: clock/baud ratio, data width, parity mode and stop-bit count.
- Adds a 2-flop RX synchroniser, 3-sample majority vote, start-glitch rejection, parity and overrun detection, and a valid/ack receive handshake.
- Sits between the board serial pins and the byte-level command/loopback logic.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_core.sv | 145 ++++++++++++++
 rtl/param_uart.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and baud divisor helper for param_uart
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_bit_clks(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: synchroniser, 3-sample majority vote, RX FSM, error flags
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_i         raw serial input (asynchronous)
//   rx_ack_i     consumer has taken rx_byte_o
//   rx_byte_o    last received data word
//   ready_o      rx_byte_o valid, held until rx_ack_i
//   frame_err_o  stop bit sampled low in the last frame
//   parity_err_o parity mismatch in the last frame
//   overrun_o    one-cycle pulse: frame completed while ready_o was still high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BIT_CLKS  = 35,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 rx_ack_i,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 ready_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int M  = BIT_CLKS / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_S2   = CW'(M + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q;
    logic [1:0]           samp_q;
    logic                 armed_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 ready_q, ferr_q, perr_q, ovr_q;

    logic rxs, maj, mid, bit_end, par_exp;

    assign rxs     = sync2_q;
    assign cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    // Third vote is the live sample, so the decision is available at M+1.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign mid     = (cnt_q == CNT_S2);
    assign bit_end = (cnt_q == CNT_LAST);
    assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            samp_q  <= '0;
            armed_q <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            byte_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            ovr_q   <= 1'b0;
            // Frame completion below overrides this clear.
            if (rx_ack_i) ready_q <= 1'b0;

            if (state_q != RX_IDLE) begin
                cnt_q <= cnt_d;
                if (cnt_q == CNT_S0) samp_q[0] <= rxs;
                if (cnt_q == CNT_S1) samp_q[1] <= rxs;
            end

            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    // Only a high-to-low transition starts a frame; a held-low
                    // line (break) leaves the receiver disarmed.
                    if (rxs) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (mid && maj)   state_q <= RX_IDLE;
                    else if (bit_end) state_q <= RX_DATA;
                end
                RX_DATA: begin
                    if (mid) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (mid)     par_q   <= maj;
                    if (bit_end) state_q <= RX_STOP;
                end
                RX_STOP: begin
                    // Finish at mid-stop so a following start edge is not missed.
                    if (mid) begin
                        byte_q  <= shift_q;
                        ferr_q  <= ~maj;
                        perr_q  <= (PARITY == PAR_NONE) ? 1'b0 : (par_q != par_exp);
                        ready_q <= 1'b1;
                        ovr_q   <= ready_q & ~rx_ack_i;
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte_o    = byte_q;
    assign ready_o      = ready_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;

endmodule

// File: rtl/param_uart.sv
// rtl/param_uart.sv - parametrised full-duplex UART top with inline transmitter
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         serial input (asynchronous)
//   tx         serial output, idles high, registered
//   tx_send    word to transmit
//   tx_ready   transmit request strobe (ignored while tx_busy)
//   tx_busy    transmitter occupied
//   rx_byte    last received word
//   ready      rx_byte valid, held until rx_ack
//   rx_ack     consumer has taken rx_byte
//   frame_err  stop bit low in last frame
//   parity_err parity mismatch in last frame
//   overrun    one-cycle pulse on completion while ready still high
module param_uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 32000000,
    parameter int BAUD      = 921600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_send,
    input  logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 ready,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUD);
    localparam int CW       = $clog2(BIT_CLKS);
    localparam int IW       = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    uart_rx_core #(
        .BIT_CLKS (BIT_CLKS),
        .DATA_BITS(DATA_BITS),
        .PARITY   (PARITY)
    ) u_rx (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rx_i        (rx),
        .rx_ack_i    (rx_ack),
        .rx_byte_o   (rx_byte),
        .ready_o     (ready),
        .frame_err_o (frame_err),
        .parity_err_o(parity_err),
        .overrun_o   (overrun)
    );

    tx_state_e            tx_state_q;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]        tx_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 tx_end;

    assign tx_cnt_d = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + CW'(1);
    assign tx_end   = (tx_cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    tx_idx_q <= '0;
                    if (tx_ready) begin
                        tx_shift_q <= tx_send;
                        tx_par_q   <= (PARITY == PAR_EVEN) ? ^tx_send : ~^tx_send;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_end) begin
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_end) begin
                        if (tx_idx_q == IDX_LAST) begin
                            tx_idx_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q       <= tx_par_q;
                                tx_state_q <= TX_PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            // Bit 0 is always the bit on the line.
                            tx_idx_q   <= tx_idx_q + IW'(1);
                            tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                            tx_q       <= tx_shift_q[1];
                        end
                    end
                end
                TX_PARITY: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_end) begin
                        tx_q       <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    tx_cnt_q <= tx_cnt_d;
                    if (tx_end) begin
                        if (tx_idx_q == STOP_LAST) begin
                            tx_idx_q   <= '0;
                            busy_q     <= 1'b0;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q + IW'(1);
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule
